// File: rtl/shadow1229_player_pkg.sv
// Shared definitions for the tune-player sequencing logic: FSM states,
// default note durations and the rest code.
package shadow1229_player_pkg;

  localparam int TICK_W = 12;

  localparam int TICKS_16TH_DEF = 326;
  localparam int TICKS_8TH_DEF  = 652;
  localparam int TICKS_4TH_DEF  = 1304;

  localparam logic [3:0] REST_CODE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_ID,
    ST_FETCH_PHRASE,
    ST_ISSUE,
    ST_HOLD,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/shadow1229_note_timer.sv
// Loadable 12-bit down-counter timing a note in tick strobes; expire fires
// on the tick that would take the count from 1 to 0.
module shadow1229_note_timer
  import shadow1229_player_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [TICK_W-1:0] i_load_val,
  input  logic              i_tick,
  input  logic              i_freeze,
  output logic              o_expire
);

  localparam logic [TICK_W-1:0] ONE = 1;

  logic [TICK_W-1:0] r_count;
  logic              w_step;

  assign w_step   = i_tick && !i_freeze && (r_count != '0);
  assign o_expire = w_step && (r_count == ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (w_step) begin
      r_count <= r_count - ONE;
    end
  end

endmodule

// File: rtl/shadow1229_note_scheduler.sv
// Tune-player sequencer: walks phrase addresses, fetches phrase rows from the
// external ROMs and offers notes one at a time to the tone generator.
// state        | meaning
// IDLE, FETCH_ID, FETCH_PHRASE | wait for run, latch phrase id, latch DB row
// ISSUE, HOLD, NEXT            | offer note, time note in ticks, advance note/phrase
module shadow1229_note_scheduler
  import shadow1229_player_pkg::*;
#(
  parameter int SONG_LEN      = 256,
  parameter int HIGHKEY_COUNT = 129,
  parameter int TICKS_16TH    = TICKS_16TH_DEF,
  parameter int TICKS_8TH     = TICKS_8TH_DEF,
  parameter int TICKS_4TH     = TICKS_4TH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              tick,
  output logic [7:0]        phrase_addr,
  input  logic [4:0]        phrase_id_in,
  output logic [3:0]        phrase_id,
  output logic              phrase_type,
  input  logic [31:0]       phrase_data,
  input  logic [7:0]        length_data,
  input  logic [2:0]        n_note_in,
  output logic              note_valid,
  input  logic              note_ready,
  output logic [3:0]        note_code,
  output logic              note_highkey,
  output logic              note_fast,
  output logic [TICK_W-1:0] note_ticks,
  output logic              gate,
  output logic              song_wrap
);

  localparam logic [7:0]        LAST_ADDR = 8'(SONG_LEN - 1);
  localparam logic [8:0]        HK_ADDR   = 9'(HIGHKEY_COUNT);
  localparam logic [TICK_W-1:0] T16       = TICK_W'(TICKS_16TH);
  localparam logic [TICK_W-1:0] T8        = TICK_W'(TICKS_8TH);
  localparam logic [TICK_W-1:0] T4        = TICK_W'(TICKS_4TH);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_addr;
  logic [3:0]        r_id;
  logic              r_type;
  logic              r_highkey;
  logic [31:0]       r_pdata;
  logic [7:0]        r_ldata;
  logic [2:0]        r_n;
  logic [2:0]        r_k;
  logic              r_wrap;

  logic [3:0]        w_code;
  logic              w_len;
  logic [TICK_W-1:0] w_ticks;
  logic              w_accept;
  logic              w_expire;
  logic              w_active;

  // Note k sits at [31-4k -: 4] and its length bit at [7-k]; ~k == 7-k here.
  assign w_code = r_pdata[{~r_k, 2'b00} +: 4];
  assign w_len  = r_ldata[~r_k];

  always_comb begin
    w_ticks = T8;
    if (r_type) w_ticks = w_len ? T8 : T16;
    else        w_ticks = w_len ? T4 : T8;
  end

  assign w_accept = (r_state == ST_ISSUE) && note_ready;
  assign w_active = (r_state == ST_ISSUE) || (r_state == ST_HOLD);

  shadow1229_note_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (w_ticks),
    .i_tick     (tick && (r_state == ST_HOLD)),
    .i_freeze   (!run),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ISSUE ignores run so an offered note is never withdrawn.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:         if (run) w_state_nxt = ST_FETCH_ID;
      ST_FETCH_ID:     if (run) w_state_nxt = ST_FETCH_PHRASE;
      ST_FETCH_PHRASE: if (run) w_state_nxt = ST_ISSUE;
      ST_ISSUE:        if (note_ready) w_state_nxt = ST_HOLD;
      ST_HOLD:         if (w_expire) w_state_nxt = ST_NEXT;
      ST_NEXT:         if (run) w_state_nxt = (r_k < r_n) ? ST_ISSUE : ST_FETCH_ID;
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_id      <= '0;
      r_type    <= 1'b0;
      r_highkey <= 1'b0;
      r_pdata   <= '0;
      r_ldata   <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (run) begin
        unique case (r_state)
          ST_FETCH_ID: begin
            r_id      <= phrase_id_in[3:0];
            r_type    <= phrase_id_in[4];
            r_highkey <= ({1'b0, r_addr} >= HK_ADDR);
          end
          ST_FETCH_PHRASE: begin
            r_pdata <= phrase_data;
            r_ldata <= length_data;
            r_n     <= n_note_in;
            r_k     <= '0;
          end
          ST_NEXT: begin
            if (r_k < r_n) begin
              r_k <= r_k + 3'd1;
            end else if (r_addr == LAST_ADDR) begin
              r_addr <= '0;
              r_wrap <= 1'b1;
            end else begin
              r_addr <= r_addr + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign phrase_addr  = r_addr;
  assign phrase_id    = r_id;
  assign phrase_type  = r_type;
  assign note_valid   = (r_state == ST_ISSUE);
  assign note_code    = w_code;
  assign note_highkey = r_highkey;
  assign note_fast    = r_type;
  assign note_ticks   = w_active ? w_ticks : '0;
  assign gate         = (r_state == ST_HOLD) && run && (w_code != REST_CODE);
  assign song_wrap    = r_wrap;

endmodule

// File: tb/tb_shadow1229_note_scheduler.sv
// Scoreboard bench for the note scheduler: a default-parameter instance plays
// hand-built phrases; a short-duration instance walks the whole song.
module tb_shadow1229_note_scheduler;

  localparam int T16 = 326;
  localparam int T8  = 652;
  localparam int T4  = 1304;

  typedef struct packed {
    logic [3:0]  code;
    logic [11:0] ticks;
    logic        hk;
    logic        fast;
  } note_t;

  typedef struct packed {
    logic [7:0] addr;
    logic       hk;
  } walk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // main instance
  logic        reset, run, note_ready, tick;
  logic [7:0]  phrase_addr;
  logic [4:0]  phrase_id_in;
  logic [3:0]  phrase_id;
  logic        phrase_type;
  logic [31:0] phrase_data;
  logic [7:0]  length_data;
  logic [2:0]  n_note_in;
  logic        note_valid, note_highkey, note_fast, gate, song_wrap;
  logic [3:0]  note_code;
  logic [11:0] note_ticks;

  int tick_period = 1;
  int tick_div    = 0;
  always @(posedge clk) tick_div <= (tick_div + 1 >= tick_period) ? 0 : tick_div + 1;
  assign tick = (tick_div == 0);

  logic [4:0]  id_rom [0:7];
  logic [31:0] pdb [0:31];
  logic [7:0]  ldb [0:31];
  logic [2:0]  ndb [0:31];

  assign phrase_id_in = id_rom[phrase_addr[2:0]];
  assign phrase_data  = pdb[{phrase_type, phrase_id}];
  assign length_data  = ldb[{phrase_type, phrase_id}];
  assign n_note_in    = ndb[{phrase_type, phrase_id}];

  shadow1229_note_scheduler u_dut (
    .clk(clk), .reset(reset), .run(run), .tick(tick),
    .phrase_addr(phrase_addr), .phrase_id_in(phrase_id_in),
    .phrase_id(phrase_id), .phrase_type(phrase_type),
    .phrase_data(phrase_data), .length_data(length_data), .n_note_in(n_note_in),
    .note_valid(note_valid), .note_ready(note_ready), .note_code(note_code),
    .note_highkey(note_highkey), .note_fast(note_fast), .note_ticks(note_ticks),
    .gate(gate), .song_wrap(song_wrap)
  );

  // walk instance: every address maps to a one-note fast phrase of 3 ticks
  logic        walk_reset, walk_run;
  logic [7:0]  walk_addr;
  logic [3:0]  walk_id, walk_code;
  logic        walk_type, walk_valid, walk_hk, walk_fast, walk_gate, walk_wrap;
  logic [11:0] walk_ticks;

  shadow1229_note_scheduler #(.TICKS_16TH(3), .TICKS_8TH(5), .TICKS_4TH(9)) u_walk (
    .clk(clk), .reset(walk_reset), .run(walk_run), .tick(1'b1),
    .phrase_addr(walk_addr), .phrase_id_in(5'h1E),
    .phrase_id(walk_id), .phrase_type(walk_type),
    .phrase_data(32'h3000_0000), .length_data(8'h00), .n_note_in(3'd0),
    .note_valid(walk_valid), .note_ready(1'b1), .note_code(walk_code),
    .note_highkey(walk_hk), .note_fast(walk_fast), .note_ticks(walk_ticks),
    .gate(walk_gate), .song_wrap(walk_wrap)
  );

  note_t sb[$];
  walk_t wsb[$];

  function automatic logic [11:0] dur(input logic fast, input logic b);
    if (fast) return b ? 12'(T8) : 12'(T16);
    return b ? 12'(T4) : 12'(T8);
  endfunction

  task automatic push_phrase(input logic [4:0] idf, input logic hk);
    note_t       e;
    logic [31:0] pd;
    logic [7:0]  ld;
    pd = pdb[idf];
    ld = ldb[idf];
    for (int k = 0; k <= int'(ndb[idf]); k++) begin
      e.code  = pd[28-4*k +: 4];
      e.ticks = dur(idf[4], ld[7-k]);
      e.hk    = hk;
      e.fast  = idf[4];
      sb.push_back(e);
    end
  endtask

  task automatic sb_pop_compare(input string name);
    note_t e;
    n_checks++;
    if (!note_valid || sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: valid=%b queued=%0d, required valid=1 with an expected note",
               name, note_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if ({note_code, note_ticks, note_highkey, note_fast} !== {e.code, e.ticks, e.hk, e.fast}) begin
      n_fail++;
      $display("FAIL %s: got code=%h ticks=%0d hk=%b fast=%b, required code=%h ticks=%0d hk=%b fast=%b",
               name, note_code, note_ticks, note_highkey, note_fast, e.code, e.ticks, e.hk, e.fast);
    end
  endtask

  // From a negedge with a handshake pending, run to the next offered note.
  task automatic measure_note(input int pause_at, input int pause_len,
                              output int gate_ticks, output int cycles, output int pause_gate);
    gate_ticks = 0;
    cycles     = 0;
    pause_gate = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (gate && tick) gate_ticks++;
      if (!run && gate) pause_gate++;
      if (pause_len > 0 && cycles == pause_at) run = 1'b0;
      if (pause_len > 0 && cycles == pause_at + pause_len) run = 1'b1;
    end while (!note_valid && cycles < 4000);
  endtask

  task automatic setup_roms;
    for (int i = 0; i < 32; i++) begin
      pdb[i] = '0; ldb[i] = '0; ndb[i] = '0;
    end
    for (int i = 0; i < 8; i++) id_rom[i] = 5'h00;
    id_rom[0] = 5'h03; pdb[3]  = 32'h1234_5678; ldb[3]  = 8'h00; ndb[3]  = 3'd7;
    id_rom[1] = 5'h11; pdb[17] = 32'h9ABC_DE01; ldb[17] = 8'h80; ndb[17] = 3'd7;
    id_rom[2] = 5'h02; pdb[2]  = 32'h7000_0000; ldb[2]  = 8'h80; ndb[2]  = 3'd0;
    id_rom[3] = 5'h14; pdb[20] = 32'hF500_0000; ldb[20] = 8'h00; ndb[20] = 3'd1;
    id_rom[4] = 5'h05; pdb[5]  = 32'hA000_0000; ldb[5]  = 8'h80; ndb[5]  = 3'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1; walk_reset = 1'b1; run = 1'b0; walk_run = 1'b0; note_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({phrase_addr, phrase_id, phrase_type, note_valid, note_code, note_highkey,
         note_fast, note_ticks, gate, song_wrap} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h id=%h type=%b valid=%b code=%h hk=%b fast=%b ticks=%0d gate=%b wrap=%b, required all 0",
               phrase_addr, phrase_id, phrase_type, note_valid, note_code, note_highkey,
               note_fast, note_ticks, gate, song_wrap);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (note_valid !== 1'b0 || phrase_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_without_run: valid=%b addr=%h, required 0/00", note_valid, phrase_addr);
    end
  endtask

  task automatic test_basic;
    int gt, cyc, pg;
    push_phrase(5'h03, 1'b0);
    run = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (note_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_plus2: valid=%b, required 0", note_valid);
    end
    @(negedge clk);
    n_checks++;
    if (note_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_plus3: valid=%b, required 1", note_valid);
    end
    for (int k = 0; k < 8; k++) begin
      sb_pop_compare($sformatf("basic_note%0d", k));
      measure_note(0, 0, gt, cyc, pg);
      n_checks++;
      if (gt != T8) begin
        n_fail++;
        $display("FAIL basic_dur%0d: ticks counted %0d, required %0d", k, gt, T8);
      end
      n_checks++;
      if (cyc != ((k < 7) ? T8 + 2 : T8 + 4)) begin
        n_fail++;
        $display("FAIL basic_gap%0d: cycles to next offer %0d, required %0d",
                 k, cyc, (k < 7) ? T8 + 2 : T8 + 4);
      end
    end
  endtask

  task automatic test_fast_lengths;
    int gt, cyc, pg;
    push_phrase(5'h11, 1'b0);
    tick_period = 2;
    for (int k = 0; k < 8; k++) begin
      sb_pop_compare($sformatf("fast_note%0d", k));
      measure_note(0, 0, gt, cyc, pg);
      n_checks++;
      if (gt != ((k == 0) ? T8 : T16)) begin
        n_fail++;
        $display("FAIL fast_dur%0d: ticks counted %0d, required %0d", k, gt, (k == 0) ? T8 : T16);
      end
    end
  endtask

  task automatic test_backpressure;
    note_t e;
    int    gt, cyc, pg;
    note_ready  = 1'b0;
    tick_period = 1;
    push_phrase(5'h02, 1'b0);
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (note_valid !== 1'b1 || gate !== 1'b0 ||
          {note_code, note_ticks, note_highkey, note_fast} !== {e.code, e.ticks, e.hk, e.fast}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b gate=%b code=%h ticks=%0d hk=%b fast=%b, required 1/0 %h/%0d/%b/%b",
                 i, note_valid, gate, note_code, note_ticks, note_highkey, note_fast,
                 e.code, e.ticks, e.hk, e.fast);
      end
      if (i == 3) run = 1'b0;
      if (i == 6) run = 1'b1;
      @(negedge clk);
    end
    note_ready = 1'b1;
    measure_note(100, 20, gt, cyc, pg);
    n_checks++;
    if (gt != T4) begin
      n_fail++;
      $display("FAIL stall_dur: ticks counted %0d, required %0d", gt, T4);
    end
    n_checks++;
    if (pg != 0) begin
      n_fail++;
      $display("FAIL pause_gate: gate high on %0d paused cycles, required 0", pg);
    end
    n_checks++;
    if (cyc != T4 + 20 + 4) begin
      n_fail++;
      $display("FAIL pause_resume: cycles to next offer %0d, required %0d", cyc, T4 + 24);
    end
  endtask

  task automatic test_rest;
    int gt, cyc, pg;
    push_phrase(5'h14, 1'b0);
    sb_pop_compare("rest_note");
    measure_note(0, 0, gt, cyc, pg);
    n_checks++;
    if (gt != 0) begin
      n_fail++;
      $display("FAIL rest_gate: gate-high ticks %0d, required 0", gt);
    end
    n_checks++;
    if (cyc != T16 + 2) begin
      n_fail++;
      $display("FAIL rest_dur: cycles to next offer %0d, required %0d", cyc, T16 + 2);
    end
    sb_pop_compare("after_rest_note");
    measure_note(0, 0, gt, cyc, pg);
    n_checks++;
    if (gt != T16) begin
      n_fail++;
      $display("FAIL after_rest_dur: ticks counted %0d, required %0d", gt, T16);
    end
  endtask

  task automatic test_reset_mid_hold;
    push_phrase(5'h05, 1'b0);
    sb_pop_compare("midreset_note");
    repeat (1005) @(negedge clk);
    n_checks++;
    if (gate !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_in_hold: gate=%b, required 1", gate);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({phrase_addr, phrase_id, phrase_type, note_valid, note_code, note_highkey,
         note_fast, note_ticks, gate, song_wrap} !== 36'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: addr=%h id=%h type=%b valid=%b code=%h ticks=%0d gate=%b, required all 0",
               phrase_addr, phrase_id, phrase_type, note_valid, note_code, note_ticks, gate);
    end
    sb.delete();
    push_phrase(5'h03, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (note_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_plus2: valid=%b, required 0", note_valid);
    end
    @(negedge clk);
    n_checks++;
    if (phrase_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL restart_addr: addr=%h, required 00", phrase_addr);
    end
    sb_pop_compare("restart_note");
    sb.delete();
  endtask

  task automatic test_walk_wrap;
    walk_t e;
    int    hs = 0, wraps = 0, cyc = 0;
    logic  prev_wrap = 1'b0;
    for (int a = 0; a < 256; a++) wsb.push_back('{addr: 8'(a), hk: (a >= 129)});
    wsb.push_back('{addr: 8'h00, hk: 1'b0});
    walk_reset = 1'b0;
    walk_run   = 1'b1;
    while (hs < 257 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (walk_wrap) begin
        wraps++;
        n_checks++;
        if (walk_addr !== 8'h00 || prev_wrap) begin
          n_fail++;
          $display("FAIL wrap_pulse: addr=%h prev_wrap=%b, required addr 00 and single-cycle pulse",
                   walk_addr, prev_wrap);
        end
      end
      prev_wrap = walk_wrap;
      if (walk_valid) begin
        hs++;
        e = wsb.pop_front();
        n_checks++;
        if ({walk_addr, walk_hk, walk_ticks} !== {e.addr, e.hk, 12'd3}) begin
          n_fail++;
          $display("FAIL walk_note: addr=%h hk=%b ticks=%0d, required addr=%h hk=%b ticks=3",
                   walk_addr, walk_hk, walk_ticks, e.addr, e.hk);
        end
      end
    end
    n_checks++;
    if (hs != 257) begin
      n_fail++;
      $display("FAIL walk_progress: notes seen %0d, required 257", hs);
    end
    n_checks++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL wrap_count: pulses %0d, required 1", wraps);
    end
  endtask

  initial begin
    setup_roms();
    test_reset();
    test_basic();
    test_fast_lengths();
    test_backpressure();
    test_rest();
    test_reset_mid_hold();
    test_walk_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shadow1229_note_scheduler.md
# shadow1229_note_scheduler

Sequencing controller for the tune player. It walks the song's phrase-address space, fetches each phrase's id, notes and lengths from the phrase ROMs, and issues one note at a time to the tone generator over a valid/ready handshake. It then times each note's duration in tick strobes and wraps at song end. It replaces the free-running counter_cycle/ticks sequencing that is currently interleaved with the tone generator.

## Interface
Parameters:
- SONG_LEN, 256: number of phrase addresses; address wraps to 0 after SONG_LEN-1.
- HIGHKEY_COUNT, 129: phrase addresses >= this play in the high key.
- TICKS_16TH, 326; TICKS_8TH, 652; TICKS_4TH, 1304: note durations in tick strobes.

Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge only.
- reset, in, 1: synchronous, active-high.
- run, in, 1: playback enable; low pauses playback.
- tick, in, 1: one-cycle timing strobe, nominally 12 kHz.
- phrase_addr, out, 8: address to the phrase-id ROM.
- phrase_id_in, in, 5: combinational ROM data; [4] is the phrase type (0 = slow, 1 = fast), [3:0] is the id.
- phrase_id, out, 4: address to the phrase DBs.
- phrase_type, out, 1: selects the phrase DB; the mux is external.
- phrase_data, in, 32: eight 4-bit note codes from the selected DB; note k is [31-4k -: 4].
- length_data, in, 8: per-note length bits from the selected DB; note k is bit [7-k].
- n_note_in, in, 3: index of the last note in the phrase (phrase plays n_note_in+1 notes).
- note_valid, out, 1: note offer to the tone generator.
- note_ready, in, 1: tone generator accepts the note.
- note_code, out, 4: frequency-table index; 4'hF means rest.
- note_highkey, out, 1: high-key table select.
- note_fast, out, 1: fast-table select (equals the latched phrase_type).
- note_ticks, out, 12: note duration.
- gate, out, 1: high while a non-rest note sounds.
- song_wrap, out, 1: one-cycle pulse when phrase_addr wraps.

## Operation
- FSM states: IDLE, FETCH_ID, FETCH_PHRASE, ISSUE, HOLD, NEXT.
- IDLE: if run, go to FETCH_ID.
- FETCH_ID: latch phrase_id and phrase_type from phrase_id_in. Latch highkey = (phrase_addr >= HIGHKEY_COUNT). Go to FETCH_PHRASE.
- FETCH_PHRASE: latch phrase_data, length_data and n_note_in. Set note index k = 0. Go to ISSUE.
- ISSUE: drive note_valid = 1 with note_code, note_highkey, note_fast and note_ticks for note k.
  - Duration when type=0: length bit 0 gives TICKS_8TH, bit 1 gives TICKS_4TH.
  - Duration when type=1: length bit 0 gives TICKS_16TH, bit 1 gives TICKS_8TH.
  - On the cycle where note_valid && note_ready, load the timer with note_ticks and go to HOLD.
  - Payload is stable while valid is high. Valid never drops before acceptance, even if run falls.
- HOLD: gate = (note_code != 4'hF). Each tick decrements the timer. A tick seen while the timer equals 1 goes to NEXT.
- NEXT:
  - If k < latched n: increment k and go to ISSUE.
  - Otherwise, if phrase_addr == SONG_LEN-1: set phrase_addr to 0 and pulse song_wrap.
  - Otherwise: increment phrase_addr.
  - In both of the last two cases, go to FETCH_ID.
- Pause: when run is low in any state other than ISSUE, state and timer freeze, ticks are ignored and gate is 0. Resuming continues exactly where playback stopped.
- Reset values: state IDLE, k 0, timer 0, and every output 0 (phrase_addr, phrase_id, phrase_type, note_valid, note_code, note_highkey, note_fast, note_ticks, gate, song_wrap).
- Reset mid-note: all of the above apply on the next edge; no note is completed.

## Timing
- Latency from run rising in IDLE: FETCH_ID at +1, FETCH_PHRASE at +2, note_valid at +3.
- Note duration is exactly note_ticks tick strobes counted after the handshake cycle. A tick in the handshake cycle itself is not counted.
- Inter-note gap when note_ready is held high: NEXT to ISSUE takes 1 cycle, so there are 2 cycles with gate low between notes in the same phrase.
- Phrase change costs 4 cycles: NEXT, FETCH_ID, FETCH_PHRASE, ISSUE.
- song_wrap is registered and high for exactly the cycle after NEXT.
- ROM inputs are sampled one cycle after their address output changes.

## Structure
- Shared package shadow1229_player_pkg holds:
  - the state enum;
  - the TICKS_16TH, TICKS_8TH and TICKS_4TH defaults;
  - REST_CODE = 4'hF;
  - the 12-bit tick width.
- One sub-module, shadow1229_note_timer: a 12-bit loadable down-counter with load, tick, freeze and expire-on-1 output.

## Test plan
- Reset, then run=1 with ROM id 5'h03, n_note_in=7 and all length bits 0. Expect note_valid at cycle +3 and 8 notes issued in order from [31:28] down to [3:0], each exactly 652 ticks long.
- phrase type=1 with length_data=8'h80. Expect note 0 with note_ticks=652 and notes 1–7 with 326, note_fast=1.
- Hold note_ready low 10 cycles, then pulse run low during ISSUE. Expect note_valid and payload stable throughout and the timer not started until the handshake.
- note_code 4'hF. Expect gate=0 for the full duration while ticks still count.
- Start at phrase_addr 128, then 129. Expect note_highkey 0 then 1. At addr 255, end of phrase: expect phrase_addr=0 and a single song_wrap pulse.
- Assert reset mid-HOLD with the timer at 300. Expect all outputs 0 next cycle, and playback restarts at phrase_addr 0.
